// File: rtl/nibble_bus_arbiter_pkg.sv
// Shared widths and FSM state encoding for the nibble bus arbiter.
package nibble_bus_arbiter_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/bus_rr_pick.sv
// Two-master round-robin picker: a lone requester wins; on a tie the master
// that did not win last time gets the bus. Output is 0 for master 0, 1 for master 1.
module bus_rr_pick (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic winner
);

   // Pick the winner from the current requests and the previous winner
   always_comb begin
      winner = 1'b0;
      if (req0 && req1) begin
         winner = ~last;
      end else if (req1) begin
         winner = 1'b1;
      end else begin
         winner = 1'b0;
      end
   end

endmodule

// File: rtl/nibble_bus_arbiter.sv
// Two-master arbiter for a 12-bit-address, 4-bit-data external nibble bus.
// Each access runs IDLE -> ADDR -> DATA (WAIT_CYCLES+1 cycles) -> DONE -> IDLE.
// All outputs are registered; they are computed from the next state so that
// each output lines up with the state it belongs to.
module nibble_bus_arbiter
   import nibble_bus_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_data_out,
   input  logic [DATA_W-1:0] bus_data_in,
   output logic              bus_data_rw
);

   localparam logic [2:0] WAIT_LD = 3'(WAIT_CYCLES);

   state_t              state_r;
   state_t              state_nx_s;
   logic [2:0]          cnt_r;
   logic                last_r;
   logic                we_r;
   logic                winner_s;
   logic                start_s;
   logic                final_data_s;
   logic                sel_we_s;
   logic [ADDR_W-1:0]   sel_addr_s;
   logic [DATA_W-1:0]   sel_wdata_s;

   logic                gnt0_r;
   logic                gnt1_r;
   logic                done0_r;
   logic                done1_r;
   logic                busy_r;
   logic                bus_data_rw_r;
   logic [DATA_W-1:0]   rdata_r;
   logic [ADDR_W-1:0]   bus_addr_r;
   logic [DATA_W-1:0]   bus_data_out_r;

   bus_rr_pick u_pick (
      .req0   (req0),
      .req1   (req1),
      .last   (last_r),
      .winner (winner_s)
   );

   assign start_s      = (state_r == IDLE) && (req0 || req1);
   assign final_data_s = (state_r == DATA) && (cnt_r == 3'd0);

   // Route the winning master's request fields
   always_comb begin
      sel_we_s    = 1'b0;
      sel_addr_s  = {ADDR_W{1'b0}};
      sel_wdata_s = {DATA_W{1'b0}};
      if (winner_s) begin
         sel_we_s    = we1;
         sel_addr_s  = addr1;
         sel_wdata_s = wdata1;
      end else begin
         sel_we_s    = we0;
         sel_addr_s  = addr0;
         sel_wdata_s = wdata0;
      end
   end

   // Next-state logic for the access sequencer
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (req0 || req1) begin
               state_nx_s = ADDR;
            end else begin
               state_nx_s = IDLE;
            end
         end
         ADDR: state_nx_s = DATA;
         DATA: begin
            if (cnt_r == 3'd0) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = DATA;
            end
         end
         DONE:    state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // DATA-phase down-counter, loaded while in ADDR
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= 3'd0;
      end else if (state_r == ADDR) begin
         cnt_r <= WAIT_LD;
      end else if ((state_r == DATA) && (cnt_r != 3'd0)) begin
         cnt_r <= cnt_r - 3'd1;
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Capture the accepted request; bus_addr/bus_data_out double as the latches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_r         <= 1'b1;
         we_r           <= 1'b0;
         bus_addr_r     <= {ADDR_W{1'b0}};
         bus_data_out_r <= {DATA_W{1'b0}};
      end else if (start_s) begin
         last_r     <= winner_s;
         we_r       <= sel_we_s;
         bus_addr_r <= sel_addr_s;
         if (sel_we_s) begin
            bus_data_out_r <= sel_wdata_s;
         end else begin
            bus_data_out_r <= bus_data_out_r;
         end
      end else begin
         last_r         <= last_r;
         we_r           <= we_r;
         bus_addr_r     <= bus_addr_r;
         bus_data_out_r <= bus_data_out_r;
      end
   end

   // Handshake pulses, busy and pin direction, aligned with the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt0_r        <= 1'b0;
         gnt1_r        <= 1'b0;
         done0_r       <= 1'b0;
         done1_r       <= 1'b0;
         busy_r        <= 1'b0;
         bus_data_rw_r <= 1'b0;
      end else begin
         gnt0_r        <= start_s && !winner_s;
         gnt1_r        <= start_s && winner_s;
         done0_r       <= final_data_s && !last_r;
         done1_r       <= final_data_s && last_r;
         busy_r        <= (state_nx_s != IDLE);
         bus_data_rw_r <= (state_nx_s == DATA) && we_r;
      end
   end

   // Read data is sampled at the end of the last DATA cycle of a read
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_r <= {DATA_W{1'b0}};
      end else if (final_data_s && !we_r) begin
         rdata_r <= bus_data_in;
      end else begin
         rdata_r <= rdata_r;
      end
   end

   assign gnt0         = gnt0_r;
   assign gnt1         = gnt1_r;
   assign done0        = done0_r;
   assign done1        = done1_r;
   assign busy         = busy_r;
   assign rdata        = rdata_r;
   assign bus_addr     = bus_addr_r;
   assign bus_data_out = bus_data_out_r;
   assign bus_data_rw  = bus_data_rw_r;

endmodule

// File: doc/nibble_bus_arbiter.md
NIBBLE_BUS_ARBITER -- requirements
Module: nibble_bus_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, extra DATA-phase cycles per access (legal 0..7).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports req0/req1  input  1 each  access request, master 0 (CPU) / master 1 (loader).
REQ-005 SHALL have ports we0/we1  input  1 each  1=write, 0=read, sampled with request.
REQ-006 SHALL have ports addr0/addr1  input  12 each  nibble address.
REQ-007 SHALL have ports wdata0/wdata1  input  4 each  write nibble.
REQ-008 SHALL have ports gnt0/gnt1  output  1 each  one-cycle pulse: request accepted.
REQ-009 SHALL have ports done0/done1  output  1 each  one-cycle pulse: access complete.
REQ-010 SHALL have port rdata  output  4  last read nibble, valid from done pulse until next read completes.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port bus_addr  output  12  external address.
REQ-013 SHALL have port bus_data_out  output  4  external write data.
REQ-014 SHALL have port bus_data_in  input  4  external read data.
REQ-015 SHALL have port bus_data_rw  output  1  1=drive data pins (write), 0=tristate (read).

Function
REQ-016 SHALL implement FSM IDLE -> ADDR -> DATA -> DONE -> IDLE.
REQ-017 IDLE: req0/req1 sampled each edge; any high -> ADDR next cycle, winner's we/addr/wdata latched.
REQ-018 Arbitration: single requester wins; both high -> master not granted last time wins (round-robin).
REQ-019 Last-winner register SHALL reset to master 1, so master 0 wins the first tie.
REQ-020 ADDR (1 cycle): gnt of winner high; bus_addr = latched address; bus_data_rw = 0.
REQ-021 DATA: lasts WAIT_CYCLES+1 cycles via 3-bit down-counter; bus_addr held.
REQ-022 DATA, write: bus_data_out = latched wdata and bus_data_rw = 1 for all DATA cycles only.
REQ-023 DATA, read: bus_data_rw = 0; bus_data_in captured into rdata at end of final DATA cycle.
REQ-024 DONE (1 cycle): done of winner high; bus_data_rw = 0; always -> IDLE.
REQ-025 Access latency: req seen at edge N -> gnt in cycle N+1, done in cycle N+3+WAIT_CYCLES.
REQ-026 Requests SHALL be ignored outside IDLE; masters drop req after gnt; req still high in IDLE starts a new access.
REQ-027 gnt0/gnt1 and done0/done1 SHALL never be high simultaneously; at most one of the four high per cycle.
REQ-028 Writes SHALL not modify rdata.
REQ-029 bus_addr/bus_data_out SHALL hold their last values in IDLE and DONE (no glitching).

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, counter 0, gnt*/done* 0, busy 0, rdata 0, bus_addr 0, bus_data_out 0, bus_data_rw 0, last-winner = 1.
REQ-031 Reset asserted mid-access SHALL abort it with no done pulse; bus_data_rw drops asynchronously.
REQ-032 First access after rst_n release SHALL start no earlier than the first rising edge with rst_n high.

Structure
REQ-033 Shared package SHALL hold ADDR_W=12, DATA_W=4, and the FSM state enum (IDLE, ADDR, DATA, DONE).
REQ-034 Combinational round-robin picker SHALL be sub-module bus_rr_pick (inputs req0, req1, last; output winner); all else in one module.

Verification
REQ-035 WAIT_CYCLES=1, req0 read addr 0x3A5, bus_data_in=0xC -> gnt0 at N+1, bus_addr=0x3A5, done0 at N+4, rdata=0xC, bus_data_rw never 1.
REQ-036 req1 write addr 0xFFF data 0x7 -> bus_data_rw=1 and bus_data_out=0x7 exactly 2 DATA cycles, done1 at N+4, rdata unchanged.
REQ-037 After reset, req0 and req1 held high together -> grants alternate 0,1,0,1 across four accesses; no simultaneous gnt/done.
REQ-038 WAIT_CYCLES=0 and =7 -> done at N+3 and N+10 respectively.
REQ-039 rst_n pulsed low during a write DATA cycle -> bus_data_rw 0 same cycle, no done, all outputs at reset values, next req serviced normally.
REQ-040 req0 raised while master 1 access in DATA -> ignored until IDLE, then gnt0 the cycle after DONE+1.
